period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 148 ++++++++++++++
 tb/tb_period_meter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Period meter: counts clk cycles between rising edges of an asynchronous input.
// Optional macro PERIOD_METER_AVG_EN reports the truncated mean of 8 consecutive periods.
module period_meter #(
    parameter int unsigned TIMEOUT_CYC = 200_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    output logic [29:0] cycle_fx,
    output logic        fx_valid,
    output logic        no_signal
);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC >= (32'd1 << 30)) begin : g_bad_timeout
        $error("period_meter: TIMEOUT_CYC must lie in 2 .. 2**30-1");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("period_meter: SYNC_STAGES must lie in 2 .. 4");
    end

    localparam logic [29:0] LIMIT = 30'(TIMEOUT_CYC);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev;
    logic                   rise;
    logic [29:0]            count;
    logic [29:0]            count_nxt;
    logic                   period_done;
    logic                   timeout;

    // NOTE: the chain resets to 0, so a sig_in already high when reset releases is seen as a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], sig_in};
            sync_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~sync_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rise) state_nxt = ARMED;
            ARMED:   if (timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    always_comb begin
        period_done = 1'b0;
        timeout     = 1'b0;
        count_nxt   = count;
        unique case (state)
            IDLE: count_nxt = rise ? 30'd1 : 30'd0;
            ARMED: begin
                if (rise) begin
                    // an edge on the limit cycle still counts as a valid period
                    period_done = 1'b1;
                    count_nxt   = 30'd1;
                end else if (count >= LIMIT) begin
                    timeout   = 1'b1;
                    count_nxt = 30'd0;
                end else begin
                    count_nxt = count + 30'd1;
                end
            end
            default: count_nxt = 30'd0;
        endcase
    end

`ifdef PERIOD_METER_AVG_EN
    logic [32:0] acc;
    logic [32:0] acc_sum;
    logic [2:0]  n_periods;
    logic        avg_last;

    assign acc_sum  = acc + {3'b000, count};
    assign avg_last = (n_periods == 3'd7);

    always_ff @(posedge clk) begin
        if (rst || timeout) begin
            acc       <= '0;
            n_periods <= '0;
        end else if (period_done) begin
            if (avg_last) begin
                acc       <= '0;
                n_periods <= '0;
            end else begin
                acc       <= acc_sum;
                n_periods <= n_periods + 3'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            cycle_fx  <= '0;
            fx_valid  <= 1'b0;
            no_signal <= 1'b1;
        end else begin
            count    <= count_nxt;
            fx_valid <= 1'b0;
            if (rise) begin
                no_signal <= 1'b0;
            end
            if (timeout) begin
                cycle_fx  <= '0;
                fx_valid  <= 1'b1;
                no_signal <= 1'b1;
            end
`ifdef PERIOD_METER_AVG_EN
            else if (period_done && avg_last) begin
                cycle_fx <= acc_sum[32:3];
                fx_valid <= 1'b1;
            end
`else
            else if (period_done) begin
                cycle_fx <= count;
                fx_valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: timestamp-based reference model compared every cycle,
// directed scenarios with hand-computed values, then randomized periods, duty cycles and resets.
module tb_period_meter;

    localparam int unsigned TIMEOUT = 1200;
    localparam int unsigned SYNC    = 2;
`ifdef PERIOD_METER_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        sig_in = 1'b0;
    logic [29:0] cycle_fx;
    logic        fx_valid;
    logic        no_signal;

    period_meter #(
        .TIMEOUT_CYC(TIMEOUT),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .cycle_fx (cycle_fx),
        .fx_valid (fx_valid),
        .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: works on the sig_in value sampled at each rising clk edge and on
    // timestamps of detected edges; a period is simply the distance between two edge times.
    bit     hist [0:SYNC];
    bit     m_init  = 1'b0;
    bit     m_armed = 1'b0;
    longint m_last  = 0;
    longint m_fx    = 0;
    bit     m_valid = 1'b0;
    bit     m_nosig = 1'b1;
    longint m_acc   = 0;
    int     m_n     = 0;
    int     pulses  = 0;

    function automatic void deliver(input longint period);
        if (AVG) begin
            m_acc += period;
            m_n++;
            if (m_n == 8) begin
                m_fx    = m_acc / 8;
                m_valid = 1'b1;
                m_acc   = 0;
                m_n     = 0;
            end
        end else begin
            m_fx    = period;
            m_valid = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        bit s;
        bit r;
        bit det;
        s = sig_in;
        r = rst;
        cyc++;
        if (r) begin
            for (int k = 0; k <= SYNC; k++) hist[k] = 1'b0;
            m_init  = 1'b1;
            m_armed = 1'b0;
            m_fx    = 0;
            m_valid = 1'b0;
            m_nosig = 1'b1;
            m_acc   = 0;
            m_n     = 0;
        end else if (m_init) begin
            // a rising edge is visible SYNC samples after it entered the chain
            det = hist[SYNC-1] & ~hist[SYNC];
            for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = s;
            m_valid = 1'b0;
            if (det) begin
                if (m_armed) deliver(cyc - m_last);
                m_armed = 1'b1;
                m_last  = cyc;
                m_nosig = 1'b0;
            end else if (m_armed && (cyc - m_last == TIMEOUT)) begin
                m_armed = 1'b0;
                m_fx    = 0;
                m_valid = 1'b1;
                m_nosig = 1'b1;
                m_acc   = 0;
                m_n     = 0;
            end
        end
        #1;
        if (m_init) begin
            check("cycle_fx", cycle_fx, m_fx);
            check("fx_valid", fx_valid, m_valid);
            check("no_signal", no_signal, m_nosig);
            if (fx_valid === 1'b1) pulses++;
        end
    end

    // All stimulus tasks start and end just after a falling clk edge.
    task automatic hold(input bit v, input int n);
        sig_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wave(input int p, input int n);
        repeat (n) begin
            hold(1'b1, p / 2);
            hold(1'b0, p - p / 2);
        end
    endtask

    task automatic edge_end();
        hold(1'b1, 1);
        hold(1'b0, 8);
    endtask

    initial begin
        int base;
        int sel;
        int p;
        int h;

        @(negedge clk);
        do_reset();
        check("reset cycle_fx", cycle_fx, 0);
        check("reset fx_valid", fx_valid, 0);
        check("reset no_signal", no_signal, 1);
        hold(1'b0, 20);
        check("idle no_signal", no_signal, 1);

        // 5 edges, 1000-clk period
        do_reset();
        base = pulses;
        wave(1000, 4);
        edge_end();
        check("p1000 pulses", pulses - base, AVG ? 0 : 4);
        check("p1000 value", cycle_fx, AVG ? 0 : 1000);
        check("p1000 no_signal", no_signal, 0);

        // fastest legal input: 2-clk period, 20 edges
        do_reset();
        base = pulses;
        wave(2, 19);
        edge_end();
        check("p2 pulses", pulses - base, AVG ? 2 : 19);
        check("p2 value", cycle_fx, 2);
        check("p2 no_signal", no_signal, 0);

        // single edge then silence: timeout, then re-arm
        do_reset();
        base = pulses;
        hold(1'b1, 5);
        hold(1'b0, TIMEOUT + 100);
        check("timeout pulses", pulses - base, 1);
        check("timeout value", cycle_fx, 0);
        check("timeout no_signal", no_signal, 1);
        base = pulses;
        wave(300, 2);
        edge_end();
        check("rearm pulses", pulses - base, AVG ? 0 : 2);
        check("rearm value", cycle_fx, AVG ? 0 : 300);
        check("rearm no_signal", no_signal, 0);

        // edges exactly TIMEOUT apart: edge wins
        do_reset();
        base = pulses;
        wave(TIMEOUT, 2);
        edge_end();
        check("limit pulses", pulses - base, AVG ? 0 : 2);
        check("limit value", cycle_fx, AVG ? 0 : TIMEOUT);
        check("limit no_signal", no_signal, 0);

        // reset about 300 cycles into a 1000-clk period
        do_reset();
        wave(1000, 2);
        hold(1'b1, 200);
        hold(1'b0, 100);
        do_reset();
        check("midrst cycle_fx", cycle_fx, 0);
        check("midrst fx_valid", fx_valid, 0);
        check("midrst no_signal", no_signal, 1);
        base = pulses;
        hold(1'b0, 700);
        wave(1000, 1);
        check("midrst arm only", pulses - base, 0);
        wave(1000, 1);
        edge_end();
        check("midrst pulses", pulses - base, AVG ? 0 : 2);
        check("midrst value", cycle_fx, AVG ? 0 : 1000);

        // periods 1000..1007
        do_reset();
        base = pulses;
        for (int q = 1000; q <= 1007; q++) wave(q, 1);
        edge_end();
        check("ramp pulses", pulses - base, AVG ? 1 : 8);
        check("ramp value", cycle_fx, AVG ? 1003 : 1007);

        // randomized periods, duty cycles, timeouts and resets
        do_reset();
        for (int it = 0; it < 120; it++) begin
            sel = int'($urandom_range(0, 11));
            if (sel == 2) begin
                rst    = 1'b1;
                sig_in = 1'($urandom_range(0, 1));
                @(negedge clk);
                rst = 1'b0;
            end else begin
                if (sel == 0)      p = int'($urandom_range(TIMEOUT - 50, TIMEOUT + 60));
                else if (sel == 1) p = TIMEOUT;
                else               p = int'($urandom_range(2, 40));
                h = int'($urandom_range(1, p - 1));
                hold(1'b1, h);
                hold(1'b0, p - h);
            end
        end
        hold(1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
